// File: rtl/ifft8_serial.sv
// Streaming 8-point radix-2 DIT inverse FFT with one time-shared butterfly, output scaled by 1/8.
// Latency: first output valid 13 edges after the 8th input is accepted (12 butterflies + 1 output load).
// Backpressure: in_ready low outside LOAD; output sample held stable while out_ready is low.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid/in_ready     input sample handshake, in_re/in_im signed samples in natural order
//   out_valid/out_ready   output sample handshake, out_re/out_im signed samples in natural order
//   out_last              marks output sample index 7
//   busy                  frame being computed or unloaded
module ifft8_serial #(
    parameter int DATA_W  = 18,
    parameter int TW_FRAC = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_re,
    input  logic signed [DATA_W-1:0] in_im,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_re,
    output logic signed [DATA_W-1:0] out_im,
    output logic                     out_last,
    output logic                     busy
);

    // Butterfly sum width and twiddle product width.
    localparam int SW = DATA_W + 2;
    localparam int PW = DATA_W + TW_FRAC + 2;

    // cos(pi/4) in TW_FRAC fraction bits (181 for TW_FRAC=8).
    localparam int TW_C = $rtoi(0.70710678 * (2.0 ** TW_FRAC) + 0.5);
    localparam logic signed [PW-1:0] TW_CS = PW'(TW_C);

    localparam logic signed [SW-1:0] SAT_MAX = SW'((2 ** (DATA_W - 1)) - 1);
    localparam logic signed [SW-1:0] SAT_MIN = SW'(-(2 ** (DATA_W - 1)));

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        COMPUTE = 2'd1,
        UNLOAD  = 2'd2
    } state_t;

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       load_hs, unload_hs;

    // Sample store: written bit-reversed on load, updated in place by the butterflies.
    logic signed [DATA_W-1:0] ram_re [8];
    logic signed [DATA_W-1:0] ram_im [8];

    function automatic logic [2:0] bitrev3(input logic [2:0] v);
        bitrev3 = {v[0], v[1], v[2]};
    endfunction

    function automatic logic signed [DATA_W-1:0] sat(input logic signed [SW-1:0] v);
        if (v > SAT_MAX)
            sat = SAT_MAX[DATA_W-1:0];
        else if (v < SAT_MIN)
            sat = SAT_MIN[DATA_W-1:0];
        else
            sat = v[DATA_W-1:0];
    endfunction

    // ------------------------------------------------------------------
    // Butterfly addressing: cnt = {stage, butterfly}.
    // Stage s pairs (top, top+span) with span = 1<<s; twiddle k = j << (2-s)
    // where j is the position of the butterfly within its group.
    // ------------------------------------------------------------------
    logic [1:0] stg, bfy;
    logic [2:0] top, bot;
    logic [1:0] tw_k;

    assign stg = cnt[3:2];
    assign bfy = cnt[1:0];

    always_comb begin
        top  = 3'd0;
        bot  = 3'd0;
        tw_k = 2'd0;
        case (stg)
            2'd0: begin
                top  = {bfy, 1'b0};
                bot  = {bfy, 1'b1};
                tw_k = 2'd0;
            end
            2'd1: begin
                top  = {bfy[1], 1'b0, bfy[0]};
                bot  = {bfy[1], 1'b1, bfy[0]};
                tw_k = {bfy[0], 1'b0};
            end
            default: begin
                top  = {1'b0, bfy};
                bot  = {1'b1, bfy};
                tw_k = bfy;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Butterfly datapath: B*w, then (A +- B*w) >>> 1 with saturation.
    // ------------------------------------------------------------------
    logic signed [SW-1:0] a_re, a_im, b_re, b_im;
    logic signed [PW-1:0] p_rr, p_ii, p_dif, p_sum, p_nsum;
    logic signed [SW-1:0] w_re, w_im;
    logic signed [SW-1:0] sum_re, sum_im, dif_re, dif_im;
    logic signed [DATA_W-1:0] res_top_re, res_top_im, res_bot_re, res_bot_im;

    assign a_re = SW'(ram_re[top]);
    assign a_im = SW'(ram_im[top]);
    assign b_re = SW'(ram_re[bot]);
    assign b_im = SW'(ram_im[bot]);

    // Only two constant products are needed: both diagonal twiddles share them.
    assign p_rr   = PW'(b_re) * TW_CS;
    assign p_ii   = PW'(b_im) * TW_CS;
    assign p_dif  = p_rr - p_ii;
    assign p_sum  = p_rr + p_ii;
    assign p_nsum = -p_sum;

    always_comb begin
        w_re = b_re;
        w_im = b_im;
        case (tw_k)
            2'd0: begin
                w_re = b_re;
                w_im = b_im;
            end
            2'd1: begin  // (c + jc)
                w_re = SW'(p_dif >>> TW_FRAC);
                w_im = SW'(p_sum >>> TW_FRAC);
            end
            2'd2: begin  // j: swap and negate
                w_re = -b_im;
                w_im = b_re;
            end
            default: begin  // (-c + jc)
                w_re = SW'(p_nsum >>> TW_FRAC);
                w_im = SW'(p_dif >>> TW_FRAC);
            end
        endcase
    end

    assign sum_re = a_re + w_re;
    assign sum_im = a_im + w_im;
    assign dif_re = a_re - w_re;
    assign dif_im = a_im - w_im;

    assign res_top_re = sat(sum_re >>> 1);
    assign res_top_im = sat(sum_im >>> 1);
    assign res_bot_re = sat(dif_re >>> 1);
    assign res_bot_im = sat(dif_im >>> 1);

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= LOAD;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        load_hs   = 1'b0;
        unload_hs = 1'b0;
        case (state)
            LOAD: begin
                if (in_valid) begin
                    load_hs = 1'b1;
                    if (cnt == 4'd7) begin
                        state_nxt = COMPUTE;
                        cnt_nxt   = 4'd0;
                    end else begin
                        cnt_nxt = cnt + 4'd1;
                    end
                end
            end
            COMPUTE: begin
                if (cnt == 4'd11) begin
                    state_nxt = UNLOAD;
                    cnt_nxt   = 4'd0;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            UNLOAD: begin
                if (out_valid && out_ready) begin
                    unload_hs = 1'b1;
                    if (cnt == 4'd7) begin
                        state_nxt = LOAD;
                        cnt_nxt   = 4'd0;
                    end else begin
                        cnt_nxt = cnt + 4'd1;
                    end
                end
            end
            default: begin
                state_nxt = LOAD;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    assign in_ready = (state == LOAD);
    assign busy     = (state == COMPUTE) || (state == UNLOAD);
    assign out_last = out_valid && (cnt == 4'd7);

    // ------------------------------------------------------------------
    // Sample store writes (no reset: contents are don't-care after reset)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (load_hs) begin
                ram_re[bitrev3(cnt[2:0])] <= in_re;
                ram_im[bitrev3(cnt[2:0])] <= in_im;
            end else if (state == COMPUTE) begin
                ram_re[top] <= res_top_re;
                ram_im[top] <= res_top_im;
                ram_re[bot] <= res_bot_re;
                ram_im[bot] <= res_bot_im;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output register. The first UNLOAD cycle primes it with sample 0;
    // afterwards it only changes on a handshake, so data holds under stall.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_re    <= '0;
            out_im    <= '0;
        end else if (state == UNLOAD) begin
            if (!out_valid) begin
                out_valid <= 1'b1;
                out_re    <= ram_re[cnt[2:0]];
                out_im    <= ram_im[cnt[2:0]];
            end else if (unload_hs) begin
                if (cnt == 4'd7) begin
                    out_valid <= 1'b0;
                end else begin
                    out_re <= ram_re[cnt_nxt[2:0]];
                    out_im <= ram_im[cnt_nxt[2:0]];
                end
            end
        end
    end

endmodule
